// File: rtl/shift_pkg.sv
// Shared constants for the multi-cycle shift sequencer and its single-pass shifter.
package shift_pkg;

   localparam int unsigned AMT_W  = 8;
   localparam int unsigned TYPE_W = 3;

   localparam logic [TYPE_W-1:0] SH_LSL = 3'b000;
   localparam logic [TYPE_W-1:0] SH_LSR = 3'b001;
   localparam logic [TYPE_W-1:0] SH_ASR = 3'b010;
   localparam logic [TYPE_W-1:0] SH_ROR = 3'b011;
   localparam logic [TYPE_W-1:0] SH_RRX = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/shift_pass.sv
// Single combinational shifter pass; step is always < N, so carry is a single masked bit.
module shift_pass
   import shift_pkg::*;
#(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0]      data,
   input  logic [AMT_W-1:0]  step,
   input  logic [TYPE_W-1:0] typ,
   input  logic              cin,
   output logic [N-1:0]      res,
   output logic              cout
);

   logic [N-1:0] msb_mask;
   logic [N-1:0] lsb_mask;

   // Select the last bit shifted out: data[N-step] for left, data[step-1] for right.
   always_comb begin
      msb_mask = {1'b1, {(N-1){1'b0}}} >> (step - AMT_W'(1));
      lsb_mask = N'(1) << (step - AMT_W'(1));
   end

   always_comb begin
      res  = data;
      cout = cin;
      unique case (typ)
         SH_LSL: begin
            res = data << step;
            if (step != '0) cout = |(data & msb_mask);
         end
         SH_LSR: begin
            res = data >> step;
            if (step != '0) cout = |(data & lsb_mask);
         end
         SH_ASR: begin
            res = $signed(data) >>> step;
            if (step != '0) cout = |(data & lsb_mask);
         end
         SH_ROR: begin
            res = (data >> step) | (data << (N - 32'(step)));
            if (step != '0) cout = res[N-1];
         end
         SH_RRX: begin
            res  = {cin, data[N-1:1]};
            cout = data[0];
         end
         default: begin
            res  = data;
            cout = cin;
         end
      endcase
   end

endmodule

// File: rtl/shift_sequencer.sv
// ARM register-specified shift executed as a series of bounded barrel-shifter passes.
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int unsigned N        = 32,
   parameter int unsigned STEP_MAX = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [N-1:0]      in_data,
   input  logic [AMT_W-1:0]  in_amt,
   input  logic [TYPE_W-1:0] in_type,
   input  logic              in_cf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [N-1:0]      out_data,
   output logic              out_cf,
   output logic              busy
);

   state_t              state, state_n;
   logic [N-1:0]        acc, acc_n;
   logic                c, c_n;
   logic [TYPE_W-1:0]   typ, typ_n;
   logic [AMT_W-1:0]    rem, rem_n;
   logic [AMT_W-1:0]    step;
   logic [N-1:0]        pass_res;
   logic                pass_cout;
   logic                out_valid_q;

   always_comb begin
      step = (32'(rem) > STEP_MAX) ? AMT_W'(STEP_MAX) : rem;
   end

   shift_pass #(.N(N)) u_pass (
      .data (acc),
      .step (step),
      .typ  (typ),
      .cin  (c),
      .res  (pass_res),
      .cout (pass_cout)
   );

   always_comb begin
      state_n = state;
      acc_n   = acc;
      c_n     = c;
      typ_n   = typ;
      rem_n   = rem;
      unique case (state)
         ST_IDLE: begin
            if (in_valid) begin
               acc_n = in_data;
               c_n   = in_cf;
               typ_n = in_type;
               unique case (in_type)
                  SH_LSL, SH_LSR, SH_ASR: rem_n = in_amt;
                  SH_ROR: begin
                     rem_n = AMT_W'(32'(in_amt) % N);
                     // Rotation by a nonzero multiple of N leaves data intact but still sets carry.
                     if (in_amt != '0 && rem_n == '0) c_n = in_data[N-1];
                  end
                  SH_RRX:  rem_n = AMT_W'(1);
                  default: rem_n = '0;
               endcase
               state_n = (rem_n != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            acc_n = pass_res;
            c_n   = pass_cout;
            rem_n = rem - step;
            if (rem_n == '0) state_n = ST_DONE;
         end
         ST_DONE: begin
            if (out_ready) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         acc         <= '0;
         c           <= 1'b0;
         typ         <= '0;
         rem         <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_n;
         acc         <= acc_n;
         c           <= c_n;
         typ         <= typ_n;
         rem         <= rem_n;
         out_valid_q <= (state_n == ST_DONE);
      end
   end

   assign in_ready  = (state == ST_IDLE) & ~rst;
   assign busy      = (state != ST_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = acc;
   assign out_cf    = c;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench: driver pushes expected results at accept, monitor checks them at the output.
module tb_shift_sequencer;
   import shift_pkg::*;

   localparam int unsigned N = 32;

   typedef struct {
      logic [N-1:0] data;
      logic         cf;
      int           t_valid;
   } exp_t;

   typedef struct {
      logic [N-1:0] d;
      logic [7:0]   amt;
      logic [2:0]   ty;
      logic         cf;
      logic [N-1:0] ed;
      logic         ecf;
      int           p;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] in_data;
   logic [7:0]   in_amt;
   logic [2:0]   in_type;
   logic         in_cf;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_data;
   logic         out_cf;
   logic         busy;

   exp_t sb[$];
   vec_t vecs[$];
   int   total   = 0;
   int   bad     = 0;
   int   cyc     = 0;
   int   last_hs = -10;
   logic prev_valid = 1'b0;

   shift_sequencer #(.N(N), .STEP_MAX(31)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_amt    (in_amt),
      .in_type   (in_type),
      .in_cf     (in_cf),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_cf    (out_cf),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h need %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compare every presented result against the scoreboard head.
   always @(negedge clk) begin
      if (out_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_valid: got data %h with empty scoreboard", out_data);
         end else begin
            if (!prev_valid) check("latency", N'(cyc), N'(sb[0].t_valid));
            check("out_data", out_data, sb[0].data);
            check("out_cf", N'(out_cf), N'(sb[0].cf));
            check("in_ready_in_done", N'(in_ready), '0);
            if (out_ready) begin
               last_hs = cyc;
               void'(sb.pop_front());
            end
         end
      end
      prev_valid = out_valid;
   end

   task automatic send(input logic [N-1:0] d, input logic [7:0] amt, input logic [2:0] ty,
                       input logic cf, input logic [N-1:0] ed, input logic ecf, input int p,
                       input bit track, output int t_acc);
      int n = 0;
      @(negedge clk);
      in_data  = d;
      in_amt   = amt;
      in_type  = ty;
      in_cf    = cf;
      in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: in_ready low for %0d cycles", n);
         t_acc = -1;
      end else begin
         t_acc = cyc;
         if (track) sb.push_back('{ed, ecf, cyc + 1 + p});
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0 || busy) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: %0d results outstanding", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t, t2;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_amt    = '0;
      in_type   = '0;
      in_cf     = 1'b0;
      out_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_out_valid", N'(out_valid), '0);
      check("rst_out_data", out_data, '0);
      check("rst_out_cf", N'(out_cf), '0);
      check("rst_busy", N'(busy), '0);
      check("rst_in_ready", N'(in_ready), '0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", N'(in_ready), N'(1));

      vecs.push_back('{32'h0000_0001, 8'd4,   SH_LSL, 1'b0, 32'h0000_0010, 1'b0, 1});
      vecs.push_back('{32'h8000_0000, 8'd32,  SH_LSR, 1'b0, 32'h0000_0000, 1'b1, 2});
      vecs.push_back('{32'h8000_0000, 8'd33,  SH_LSR, 1'b1, 32'h0000_0000, 1'b0, 2});
      vecs.push_back('{32'h8000_0000, 8'd200, SH_ASR, 1'b0, 32'hFFFF_FFFF, 1'b1, 7});
      vecs.push_back('{32'hFFFF_FFFF, 8'd0,   SH_LSL, 1'b1, 32'hFFFF_FFFF, 1'b1, 0});
      vecs.push_back('{32'h0000_0001, 8'd33,  SH_ROR, 1'b0, 32'h8000_0000, 1'b1, 1});
      vecs.push_back('{32'h8000_0001, 8'd64,  SH_ROR, 1'b0, 32'h8000_0001, 1'b1, 0});
      vecs.push_back('{32'h0000_0003, 8'd0,   SH_RRX, 1'b1, 32'h8000_0001, 1'b1, 1});
      vecs.push_back('{32'h0000_0001, 8'd32,  SH_LSL, 1'b0, 32'h0000_0000, 1'b1, 2});
      vecs.push_back('{32'h4000_0000, 8'd255, SH_ASR, 1'b1, 32'h0000_0000, 1'b0, 9});
      vecs.push_back('{32'hF000_0000, 8'd28,  SH_LSR, 1'b1, 32'h0000_000F, 1'b0, 1});
      vecs.push_back('{32'h0000_000F, 8'd29,  SH_LSL, 1'b0, 32'hE000_0000, 1'b1, 1});
      vecs.push_back('{32'h1234_5678, 8'd0,   SH_ROR, 1'b1, 32'h1234_5678, 1'b1, 0});
      vecs.push_back('{32'h0000_1234, 8'd7,   3'b101, 1'b0, 32'h0000_1234, 1'b0, 0});
      vecs.push_back('{32'h8000_0000, 8'd40,  SH_LSL, 1'b1, 32'h0000_0000, 1'b0, 2});

      foreach (vecs[i])
         send(vecs[i].d, vecs[i].amt, vecs[i].ty, vecs[i].cf, vecs[i].ed, vecs[i].ecf,
              vecs[i].p, 1'b1, t);
      drain();

      // Backpressure: result held for 5 cycles, second request waits for the handshake.
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(32'h0000_0100, 8'd8, SH_LSR, 1'b0, 32'h0000_0001, 1'b0, 1, 1'b1, t);
      fork
         begin
            int n = 0;
            while (!out_valid && n < 50) begin
               @(negedge clk);
               n++;
            end
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
         begin
            send(32'h0000_0001, 8'd1, SH_ROR, 1'b0, 32'h8000_0000, 1'b1, 1, 1'b1, t2);
            check("holdoff_accept", N'(t2), N'(last_hs + 1));
         end
      join
      drain();

      // Reset in the middle of a long LSL drops the operation.
      send(32'h0000_0001, 8'd255, SH_LSL, 1'b0, '0, 1'b0, 0, 1'b0, t);
      repeat (3) @(negedge clk);
      check("midrun_busy", N'(busy), N'(1));
      rst = 1'b1;
      @(negedge clk);
      check("midrst_out_valid", N'(out_valid), '0);
      check("midrst_out_data", out_data, '0);
      check("midrst_out_cf", N'(out_cf), '0);
      check("midrst_busy", N'(busy), '0);
      check("midrst_in_ready", N'(in_ready), '0);
      rst = 1'b0;
      #1;
      check("midrst_in_ready_after", N'(in_ready), N'(1));
      send(32'h0000_0001, 8'd1, SH_LSL, 1'b0, 32'h0000_0002, 1'b0, 1, 1'b1, t);
      drain();

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
